// File: rtl/ddr_pkg.sv
// Shared constants, FSM state encoding and multiplier lookup for the combo tracker.
package ddr_pkg;

  localparam int          COMBO_MAX   = 999;
  localparam logic [9:0]  MULT_T1     = 10'd10;
  localparam logic [9:0]  MULT_T2     = 10'd20;
  localparam logic [9:0]  MULT_T3     = 10'd30;
  localparam logic [7:0]  BASE_POINTS = 8'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic logic [2:0] mult_for(input logic [9:0] c);
    logic [2:0] m;
    if (c >= MULT_T3)      m = 3'd4;
    else if (c >= MULT_T2) m = 3'd3;
    else if (c >= MULT_T1) m = 3'd2;
    else                   m = 3'd1;
    return m;
  endfunction

endpackage

// File: rtl/lane_arbiter.sv
// Lowest-index-first priority encoder over pending lanes: one-hot grant plus any-valid.
module lane_arbiter #(
  parameter int LANES = 8
) (
  input  logic [LANES-1:0] req_i,
  output logic [LANES-1:0] grant_o,
  output logic             any_o
);

  // below[gi] is set when some lane with index < gi is requesting
  logic [LANES:0] below;

  assign below[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_prio
      assign grant_o[gi]  = req_i[gi] & ~below[gi];
      assign below[gi+1]  = below[gi] | req_i[gi];
    end
  endgenerate

  assign any_o = below[LANES];

endmodule

// File: rtl/combo_tracker.sv
// Rhythm-game combo tracker: queues per-lane note results, drains one per cycle,
// and maintains combo, max combo, score multiplier, per-hit points and drop count.
module combo_tracker #(
  parameter int LANES     = 8,
  parameter int COMBO_MAX = ddr_pkg::COMBO_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [LANES-1:0] noteAction,
  input  logic [LANES-1:0] noteSuccessState,
  output logic [9:0]       combo,
  output logic [9:0]       maxCombo,
  output logic [2:0]       multiplier,
  output logic             pointsValid,
  output logic [7:0]       points,
  output logic [7:0]       dropCount,
  output logic             busy
);

  import ddr_pkg::*;

  localparam logic [9:0] COMBO_CAP = 10'(COMBO_MAX);

  state_e           state_q, state_d;
  logic [LANES-1:0] pend_v_q, pend_v_d;
  logic [LANES-1:0] pend_h_q, pend_h_d;
  logic [9:0]       combo_q, combo_d;
  logic [9:0]       max_q, max_d;
  logic [2:0]       mult_q, mult_d;
  logic             pv_q, pv_d;
  logic [7:0]       points_q, points_d;
  logic [7:0]       drop_q, drop_d;
  logic             busy_q, busy_d;

  logic [LANES-1:0] grant;
  logic             any_pending;
  logic [LANES-1:0] svc, held, dropped, accept;
  logic [8:0]       drop_inc, drop_sum;

  lane_arbiter #(.LANES(LANES)) u_arb (
    .req_i   (pend_v_q),
    .grant_o (grant),
    .any_o   (any_pending)
  );

  always_comb begin
    state_d  = state_q;
    combo_d  = combo_q;
    max_d    = max_q;
    mult_d   = mult_q;
    pv_d     = 1'b0;
    points_d = points_q;

    svc     = (state_q == DRAIN && any_pending) ? grant : '0;
    // A lane still waiting after this cycle's service cannot take a new event
    held    = pend_v_q & ~svc;
    dropped = noteAction & held;
    accept  = noteAction & ~held;

    pend_v_d = held | accept;
    pend_h_d = (pend_h_q & ~accept) | (noteSuccessState & accept);

    if (|svc) begin
      if (|(svc & pend_h_q)) begin
        combo_d  = (combo_q >= COMBO_CAP) ? COMBO_CAP : combo_q + 10'd1;
        mult_d   = mult_for(combo_d);
        pv_d     = 1'b1;
        points_d = BASE_POINTS * {5'd0, mult_q};
        if (combo_d > max_q) max_d = combo_d;
      end else begin
        combo_d = 10'd0;
        mult_d  = 3'd1;
      end
    end

    drop_inc = '0;
    for (int i = 0; i < LANES; i++) drop_inc = drop_inc + 9'(dropped[i]);
    drop_sum = {1'b0, drop_q} + drop_inc;
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    case (state_q)
      IDLE:    if (|pend_v_d)  state_d = DRAIN;
      DRAIN:   if (!(|pend_v_d)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = |pend_v_d;

    if (clear) begin
      state_d  = IDLE;
      pend_v_d = '0;
      pend_h_d = '0;
      combo_d  = '0;
      max_d    = '0;
      mult_d   = 3'd1;
      pv_d     = 1'b0;
      points_d = '0;
      drop_d   = '0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_v_q <= '0;
      pend_h_q <= '0;
      combo_q  <= '0;
      max_q    <= '0;
      mult_q   <= 3'd1;
      pv_q     <= 1'b0;
      points_q <= '0;
      drop_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      pend_h_q <= pend_h_d;
      combo_q  <= combo_d;
      max_q    <= max_d;
      mult_q   <= mult_d;
      pv_q     <= pv_d;
      points_q <= points_d;
      drop_q   <= drop_d;
      busy_q   <= busy_d;
    end
  end

  assign combo       = combo_q;
  assign maxCombo    = max_q;
  assign multiplier  = mult_q;
  assign pointsValid = pv_q;
  assign points      = points_q;
  assign dropCount   = drop_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_combo_tracker.sv
// Directed self-checking bench for combo_tracker.
module tb_combo_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] noteAction = '0;
  logic [7:0] noteSuccessState = '0;
  logic [9:0] combo, maxCombo;
  logic [2:0] multiplier;
  logic       pointsValid;
  logic [7:0] points, dropCount;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int n_strobes = 0;
  logic [7:0] last_points = '0;

  combo_tracker #(.LANES(8), .COMBO_MAX(999)) dut (
    .clk              (clk),
    .rst              (rst),
    .clear            (clear),
    .noteAction       (noteAction),
    .noteSuccessState (noteSuccessState),
    .combo            (combo),
    .maxCombo         (maxCombo),
    .multiplier       (multiplier),
    .pointsValid      (pointsValid),
    .points           (points),
    .dropCount        (dropCount),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pointsValid === 1'b1) begin
      n_strobes++;
      last_points = points;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Lane 0 struck with a hit every cycle for n cycles; each strike re-pends as it is serviced
  task automatic hit_stream(input int n);
    noteAction = 8'h01;
    noteSuccessState = 8'h01;
    step(n);
    noteAction = '0;
    noteSuccessState = '0;
    step(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_vec++; if (combo !== 10'd0) begin n_err++; $display("FAIL reset_combo got %0d want 0", combo); end
    n_vec++; if (maxCombo !== 10'd0) begin n_err++; $display("FAIL reset_max got %0d want 0", maxCombo); end
    n_vec++; if (multiplier !== 3'd1) begin n_err++; $display("FAIL reset_mult got %0d want 1", multiplier); end
    n_vec++; if (points !== 8'd0 || pointsValid !== 1'b0) begin n_err++; $display("FAIL reset_points got %0d/%b want 0/0", points, pointsValid); end
    n_vec++; if (dropCount !== 8'd0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_drop_busy got %0d/%b want 0/0", dropCount, busy); end
    rst = 1'b0;
    step(1);
    $display("test_reset: combo=%0d mult=%0d busy=%b", combo, multiplier, busy);
  endtask

  task automatic test_single_hits();
    for (int k = 1; k <= 10; k++) begin
      noteAction = 8'h01;
      noteSuccessState = 8'h01;
      step(1);
      noteAction = '0;
      noteSuccessState = '0;
      n_vec++; if (busy !== 1'b1 || combo !== 10'(k - 1)) begin n_err++; $display("FAIL single_pending hit %0d busy %b combo %0d want 1/%0d", k, busy, combo, k - 1); end
      step(1);
      n_vec++; if (combo !== 10'(k) || pointsValid !== 1'b1 || points !== 8'd10) begin
        n_err++; $display("FAIL single_hit %0d got combo %0d pv %b pts %0d want %0d/1/10", k, combo, pointsValid, points, k);
      end
      step(1);
      n_vec++; if (pointsValid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle %0d got pv %b busy %b want 0/0", k, pointsValid, busy); end
    end
    n_vec++; if (multiplier !== 3'd2 || maxCombo !== 10'd10) begin n_err++; $display("FAIL single_final got mult %0d max %0d want 2/10", multiplier, maxCombo); end
    $display("test_single_hits: combo=%0d mult=%0d max=%0d strobes=%0d", combo, multiplier, maxCombo, n_strobes);
  endtask

  task automatic test_miss();
    int s0;
    hit_stream(15);
    n_vec++; if (combo !== 10'd25 || multiplier !== 3'd3 || last_points !== 8'd30) begin
      n_err++; $display("FAIL miss_setup got combo %0d mult %0d pts %0d want 25/3/30", combo, multiplier, last_points);
    end
    s0 = n_strobes;
    noteAction = 8'h08;
    noteSuccessState = 8'h00;
    step(1);
    noteAction = '0;
    step(2);
    n_vec++; if (combo !== 10'd0 || multiplier !== 3'd1 || maxCombo !== 10'd25) begin
      n_err++; $display("FAIL miss_result got combo %0d mult %0d max %0d want 0/1/25", combo, multiplier, maxCombo);
    end
    n_vec++; if (n_strobes !== s0) begin n_err++; $display("FAIL miss_strobe got %0d strobes want %0d", n_strobes, s0); end
    $display("test_miss: combo=%0d mult=%0d max=%0d", combo, multiplier, maxCombo);
  endtask

  task automatic test_burst();
    int s0;
    do_clear();
    n_vec++; if (combo !== 10'd0 || maxCombo !== 10'd0 || multiplier !== 3'd1) begin
      n_err++; $display("FAIL clear_state got combo %0d max %0d mult %0d want 0/0/1", combo, maxCombo, multiplier);
    end
    s0 = n_strobes;
    noteAction = 8'hFF;
    noteSuccessState = 8'hFF;
    step(1);
    noteAction = '0;
    noteSuccessState = '0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL burst_busy0 got %b want 1", busy); end
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_vec++; if (combo !== 10'(k) || pointsValid !== 1'b1 || points !== 8'd10 || busy !== (k < 8)) begin
        n_err++; $display("FAIL burst_%0d got combo %0d pv %b pts %0d busy %b want %0d/1/10/%b", k, combo, pointsValid, points, busy, k, (k < 8));
      end
    end
    step(1);
    n_vec++; if (busy !== 1'b0 || pointsValid !== 1'b0 || n_strobes - s0 !== 8) begin
      n_err++; $display("FAIL burst_end got busy %b pv %b strobes %0d want 0/0/8", busy, pointsValid, n_strobes - s0);
    end
    $display("test_burst: combo=%0d strobes=%0d", combo, n_strobes - s0);
  endtask

  task automatic test_order();
    do_clear();
    noteAction = 8'hFF;
    noteSuccessState = 8'h0F;
    step(1);
    noteAction = '0;
    noteSuccessState = '0;
    step(4);
    n_vec++; if (combo !== 10'd4) begin n_err++; $display("FAIL order_hits got combo %0d want 4", combo); end
    step(1);
    n_vec++; if (combo !== 10'd0 || multiplier !== 3'd1) begin n_err++; $display("FAIL order_miss got combo %0d mult %0d want 0/1", combo, multiplier); end
    step(4);
    n_vec++; if (combo !== 10'd0 || maxCombo !== 10'd4 || busy !== 1'b0) begin
      n_err++; $display("FAIL order_end got combo %0d max %0d busy %b want 0/4/0", combo, maxCombo, busy);
    end
    $display("test_order: combo=%0d max=%0d", combo, maxCombo);
  endtask

  task automatic test_drop();
    do_clear();
    noteAction = 8'h3F;
    noteSuccessState = 8'h3F;
    step(1);
    noteAction = 8'h20;
    noteSuccessState = 8'h20;
    step(1);
    noteAction = '0;
    noteSuccessState = '0;
    n_vec++; if (dropCount !== 8'd1) begin n_err++; $display("FAIL drop_count got %0d want 1", dropCount); end
    step(7);
    n_vec++; if (combo !== 10'd6 || busy !== 1'b0 || dropCount !== 8'd1) begin
      n_err++; $display("FAIL drop_end got combo %0d busy %b drops %0d want 6/0/1", combo, busy, dropCount);
    end
    $display("test_drop: combo=%0d drops=%0d", combo, dropCount);
  endtask

  task automatic test_clear_priority();
    int s0;
    noteAction = 8'h03;
    noteSuccessState = 8'h03;
    step(1);
    s0 = n_strobes;
    clear = 1'b1;
    noteAction = 8'hFF;
    noteSuccessState = 8'hFF;
    step(1);
    clear = 1'b0;
    noteAction = '0;
    noteSuccessState = '0;
    n_vec++; if (combo !== 10'd0 || maxCombo !== 10'd0 || dropCount !== 8'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL clear_prio got combo %0d max %0d drops %0d busy %b want 0/0/0/0", combo, maxCombo, dropCount, busy);
    end
    step(3);
    n_vec++; if (busy !== 1'b0 || combo !== 10'd0 || n_strobes !== s0) begin
      n_err++; $display("FAIL clear_discard got busy %b combo %0d strobes %0d want 0/0/%0d", busy, combo, n_strobes, s0);
    end
    $display("test_clear_priority: combo=%0d busy=%b", combo, busy);
  endtask

  task automatic test_saturation();
    int s0;
    hit_stream(1000);
    n_vec++; if (combo !== 10'd999 || multiplier !== 3'd4 || maxCombo !== 10'd999) begin
      n_err++; $display("FAIL sat_state got combo %0d mult %0d max %0d want 999/4/999", combo, multiplier, maxCombo);
    end
    n_vec++; if (last_points !== 8'd40) begin n_err++; $display("FAIL sat_points got %0d want 40", last_points); end
    noteAction = 8'h0F;
    noteSuccessState = 8'h0F;
    step(1);
    noteAction = '0;
    noteSuccessState = '0;
    step(1);
    n_vec++; if (combo !== 10'd999 || pointsValid !== 1'b1 || points !== 8'd40) begin
      n_err++; $display("FAIL sat_hold got combo %0d pv %b pts %0d want 999/1/40", combo, pointsValid, points);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (combo !== 10'd0 || maxCombo !== 10'd0 || multiplier !== 3'd1 || busy !== 1'b0 ||
                 pointsValid !== 1'b0 || points !== 8'd0 || dropCount !== 8'd0) begin
      n_err++; $display("FAIL async_rst got combo %0d max %0d mult %0d busy %b pv %b pts %0d", combo, maxCombo, multiplier, busy, pointsValid, points);
    end
    step(1);
    rst = 1'b0;
    s0 = n_strobes;
    step(6);
    n_vec++; if (n_strobes !== s0 || busy !== 1'b0 || combo !== 10'd0) begin
      n_err++; $display("FAIL rst_abandon got strobes %0d busy %b combo %0d want %0d/0/0", n_strobes, busy, combo, s0);
    end
    $display("test_saturation: combo=%0d busy=%b", combo, busy);
  endtask

  initial begin
    test_reset();
    test_single_hits();
    test_miss();
    test_burst();
    test_order();
    test_drop();
    test_clear_priority();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
